// File: rtl/axi_dma_wr_burst.sv
// axi_dma_wr_burst: FIFO-fed AXI4 INCR write-burst master, bursts split at MAX_BURST and 4 KB; AXI_DMA_WR_STATS_EN adds o_burst_cnt/o_stall_cnt
module axi_dma_wr_burst #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 16,
    parameter int LEN_W     = 16
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    input  logic [ADDR_W-1:0]   i_dst_addr,
    input  logic [LEN_W-1:0]    i_len_words,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_err,
    input  logic                i_fifo_empty,
    output logic                o_fifo_rd_en,
    input  logic [DATA_W-1:0]   i_fifo_rd_data,
    output logic [ADDR_W-1:0]   o_awaddr,
    output logic [7:0]          o_awlen,
    output logic [2:0]          o_awsize,
    output logic [1:0]          o_awburst,
    output logic                o_awvalid,
    input  logic                i_awready,
    output logic [DATA_W-1:0]   o_wdata,
    output logic [DATA_W/8-1:0] o_wstrb,
    output logic                o_wlast,
    output logic                o_wvalid,
    input  logic                i_wready,
    input  logic [1:0]          i_bresp,
    input  logic                i_bvalid,
    output logic                o_bready
`ifdef AXI_DMA_WR_STATS_EN
    ,
    output logic [15:0]         o_burst_cnt,
    output logic [15:0]         o_stall_cnt
`endif
);
    typedef enum logic [2:0] {IDLE, AW, W, B, DONE} state_t;
    state_t state, state_n;
    logic [ADDR_W-1:0] addr, addr_nx;
    logic [LEN_W-1:0] rem, rem_nx;
    logic [7:0] awlen;
    logic [8:0] beats, rd_left, wr_left;
    logic [DATA_W-1:0] b0, b1;
    logic [1:0] cnt;
    logic inflight, go, pop, aw_hs, b_hs;
    function automatic logic [7:0] len_f(input logic [11:0] a, input logic [LEN_W-1:0] r);
        logic [31:0] p, m;
        p = (32'd4096 - {20'd0, a}) >> 2;
        m = (32'(r) < 32'(MAX_BURST)) ? 32'(r) : 32'(MAX_BURST);
        return 8'((m < p ? m : p) - 32'd1);
    endfunction
    assign beats = {1'b0, awlen} + 9'd1;
    assign addr_nx = addr + ADDR_W'({beats, 2'b00});
    assign rem_nx = rem - LEN_W'(beats);
    assign go = i_start && (state == IDLE || state == DONE);
    assign pop = o_wvalid && i_wready;
    assign aw_hs = o_awvalid && i_awready;
    assign b_hs = o_bready && i_bvalid;
    assign o_awsize = 3'b010;
    assign o_awburst = 2'b01;
    assign o_wstrb = '1;
    assign o_awaddr = addr;
    assign o_awlen = awlen;
    assign o_wdata = b0;
    assign o_busy = state inside {AW, W, B};
    assign o_done = state == DONE;
    assign o_awvalid = state == AW;
    assign o_bready = state == B;
    assign o_wvalid = cnt != 2'd0;
    assign o_wlast = o_wvalid && wr_left == 9'd1;
    assign o_fifo_rd_en = state == W && rd_left != 9'd0 && !i_fifo_empty &&
                          ({1'b0, cnt} + 3'(inflight) - 3'(pop)) < 3'd2;
    always_comb begin
        state_n = state;
        case (state)
            IDLE, DONE: state_n = go ? (i_len_words != '0 ? AW : DONE) : IDLE;
            AW:         state_n = aw_hs ? W : AW;
            W:          state_n = (pop && wr_left == 9'd1) ? B : W;
            B:          state_n = b_hs ? ((i_bresp != 2'b00 || rem_nx == '0) ? DONE : AW) : B;
            default:    state_n = IDLE;
        endcase
    end
    always_ff @(posedge i_clk) state <= i_rst ? IDLE : state_n;
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            addr     <= '0;
            rem      <= '0;
            awlen    <= '0;
            rd_left  <= '0;
            wr_left  <= '0;
            b0       <= '0;
            b1       <= '0;
            cnt      <= '0;
            inflight <= 1'b0;
            o_err    <= 1'b0;
        end else begin
            inflight <= o_fifo_rd_en;
            cnt <= cnt - 2'(pop) + 2'(inflight);
            if (pop) b0 <= b1;
            if (inflight) begin
                if (cnt == 2'(pop)) b0 <= i_fifo_rd_data;
                else b1 <= i_fifo_rd_data;
            end
            if (o_fifo_rd_en) rd_left <= rd_left - 9'd1;
            if (pop) wr_left <= wr_left - 9'd1;
            if (aw_hs) begin
                rd_left <= beats;
                wr_left <= beats;
            end
            if (go) begin
                addr  <= {i_dst_addr[ADDR_W-1:2], 2'b00};
                rem   <= i_len_words;
                awlen <= len_f(i_dst_addr[11:0] & 12'hFFC, i_len_words);
                o_err <= 1'b0;
            end
            if (b_hs) begin
                addr  <= addr_nx;
                rem   <= rem_nx;
                awlen <= len_f(addr_nx[11:0], rem_nx);
                if (i_bresp != 2'b00) o_err <= 1'b1;
            end
        end
    end
`ifdef AXI_DMA_WR_STATS_EN
    always_ff @(posedge i_clk) begin
        if (i_rst || go) begin
            o_burst_cnt <= '0;
            o_stall_cnt <= '0;
        end else begin
            if (aw_hs && o_burst_cnt != '1) o_burst_cnt <= o_burst_cnt + 16'd1;
            if (state == W && !pop && o_stall_cnt != '1) o_stall_cnt <= o_stall_cnt + 16'd1;
        end
    end
`endif
endmodule
